// File: rtl/calc_input_parser.sv
// Keypad-driven expression parser: assembles decimal operands, issues two-operand ALU requests
// and folds results back as the running value so chained expressions evaluate left to right.
module calc_input_parser #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_op_a,
  output logic [WIDTH-1:0] o_op_b,
  output logic [1:0]       o_opcode,
  output logic             o_op_valid,
  input  logic             i_op_ready,
  input  logic [WIDTH-1:0] i_res_data,
  input  logic             i_res_error,
  input  logic             i_res_valid,
  output logic [WIDTH-1:0] o_disp_value,
  output logic             o_disp_error
);

  localparam int unsigned DW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [2:0] {
    StEnterA,
    StOpWait,
    StEnterB,
    StIssue,
    StWaitRes,
    StShowRes,
    StError
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [DW-1:0]    digits_q, digits_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       next_op_q, next_op_d;
  logic             chain_q, chain_d;

  logic             key_take;
  logic             key_digit;
  logic             key_op;
  logic             key_ac;
  logic             key_eq;
  logic [1:0]       key_opcode;
  logic [WIDTH-1:0] digit_val;
  logic             digit_room;
  logic [WIDTH-1:0] a_acc;
  logic [WIDTH-1:0] b_acc;

  assign o_ready    = (state_q != StIssue) && (state_q != StWaitRes);
  assign key_take   = i_valid && o_ready;
  assign key_digit  = (i_data <= 5'd9);
  assign key_op     = (i_data >= 5'd17) && (i_data <= 5'd20);
  assign key_ac     = (i_data == 5'd16);
  assign key_eq     = (i_data == 5'd21);
  assign digit_val  = WIDTH'(i_data[3:0]);
  assign digit_room = (digits_q < DW'(MAX_DIGITS));
  assign a_acc      = a_q * WIDTH'(10) + digit_val;
  assign b_acc      = b_q * WIDTH'(10) + digit_val;

  always_comb begin
    key_opcode = 2'b00;
    case (i_data)
      5'd18:   key_opcode = 2'b01;
      5'd19:   key_opcode = 2'b10;
      5'd20:   key_opcode = 2'b11;
      default: key_opcode = 2'b00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    digits_d  = digits_q;
    op_d      = op_q;
    next_op_d = next_op_q;
    chain_d   = chain_q;

    if (key_take && key_ac) begin
      a_d      = '0;
      b_d      = '0;
      digits_d = '0;
      op_d     = 2'b00;
      chain_d  = 1'b0;
      state_d  = StEnterA;
    end else begin
      case (state_q)
        StEnterA: begin
          if (key_take && key_digit) begin
            // Digits beyond the limit are consumed but dropped.
            if (digit_room) begin
              a_d      = a_acc;
              digits_d = digits_q + DW'(1);
            end
          end else if (key_take && key_op) begin
            op_d    = key_opcode;
            state_d = StOpWait;
          end
        end
        StOpWait: begin
          if (key_take && key_digit) begin
            b_d      = digit_val;
            digits_d = DW'(1);
            state_d  = StEnterB;
          end else if (key_take && key_op) begin
            op_d = key_opcode;
          end
        end
        StEnterB: begin
          if (key_take && key_digit) begin
            if (digit_room) begin
              b_d      = b_acc;
              digits_d = digits_q + DW'(1);
            end
          end else if (key_take && key_op) begin
            next_op_d = key_opcode;
            chain_d   = 1'b1;
            state_d   = StIssue;
          end else if (key_take && key_eq) begin
            chain_d = 1'b0;
            state_d = StIssue;
          end
        end
        StIssue: begin
          if (i_op_ready) begin
            state_d = StWaitRes;
          end
        end
        StWaitRes: begin
          if (i_res_valid) begin
            if (i_res_error) begin
              state_d = StError;
            end else begin
              a_d = i_res_data;
              if (chain_q) begin
                op_d    = next_op_q;
                state_d = StOpWait;
              end else begin
                state_d = StShowRes;
              end
            end
          end
        end
        StShowRes: begin
          // A digit starts a fresh calculation; an operator continues from the result.
          if (key_take && key_digit) begin
            a_d      = digit_val;
            digits_d = DW'(1);
            state_d  = StEnterA;
          end else if (key_take && key_op) begin
            op_d    = key_opcode;
            state_d = StOpWait;
          end
        end
        StError: begin
          state_d = StError;
        end
        default: begin
          state_d = StEnterA;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StEnterA;
      a_q       <= '0;
      b_q       <= '0;
      digits_q  <= '0;
      op_q      <= 2'b00;
      next_op_q <= 2'b00;
      chain_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      digits_q  <= digits_d;
      op_q      <= op_d;
      next_op_q <= next_op_d;
      chain_q   <= chain_d;
    end
  end

  assign o_op_a     = a_q;
  assign o_op_b     = b_q;
  assign o_opcode   = op_q;
  assign o_op_valid = (state_q == StIssue);

  always_comb begin
    o_disp_value = a_q;
    o_disp_error = 1'b0;
    case (state_q)
      StEnterB, StIssue, StWaitRes: o_disp_value = b_q;
      StError: begin
        o_disp_value = '0;
        o_disp_error = 1'b1;
      end
      default: o_disp_value = a_q;
    endcase
  end

endmodule

// File: tb/tb_calc_input_parser.sv
// Directed test-plan steps followed by a randomized key stream checked against a calculator model.
module tb_calc_input_parser;

  localparam int K_AC = 16, K_ADD = 17, K_SUB = 18, K_MUL = 19, K_DIV = 20, K_EQ = 21;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  i_data = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [15:0] o_op_a, o_op_b;
  logic [1:0]  o_opcode;
  logic        o_op_valid;
  logic        i_op_ready = 1'b0;
  logic [15:0] i_res_data = '0;
  logic        i_res_error = 1'b0;
  logic        i_res_valid = 1'b0;
  logic [15:0] o_disp_value;
  logic        o_disp_error;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  calc_input_parser #(.WIDTH(16), .MAX_DIGITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_op_a       (o_op_a),
    .o_op_b       (o_op_b),
    .o_opcode     (o_opcode),
    .o_op_valid   (o_op_valid),
    .i_op_ready   (i_op_ready),
    .i_res_data   (i_res_data),
    .i_res_error  (i_res_error),
    .i_res_valid  (i_res_valid),
    .o_disp_value (o_disp_value),
    .o_disp_error (o_disp_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Tasks start and end #1 after a rising edge.
  task automatic send_key(input int k);
    int n = 0;
    i_valid = 1'b1;
    i_data  = 5'(k);
    while (o_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("key_ready_timeout", {31'd0, o_ready}, 32'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic alu_serve(input logic [15:0] ea, input logic [15:0] eb, input logic [1:0] eo,
                           input logic [15:0] res, input logic err, input int stall,
                           input string tag);
    check({tag, "_valid"}, {31'd0, o_op_valid}, 32'd1);
    check({tag, "_a"}, {16'd0, o_op_a}, {16'd0, ea});
    check({tag, "_b"}, {16'd0, o_op_b}, {16'd0, eb});
    check({tag, "_opc"}, {30'd0, o_opcode}, {30'd0, eo});
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, {31'd0, o_op_valid}, 32'd1);
      check({tag, "_hold_ready"}, {31'd0, o_ready}, 32'd0);
      check({tag, "_hold_a"}, {16'd0, o_op_a}, {16'd0, ea});
      check({tag, "_hold_b"}, {16'd0, o_op_b}, {16'd0, eb});
      check({tag, "_hold_opc"}, {30'd0, o_opcode}, {30'd0, eo});
    end
    i_op_ready = 1'b1;
    @(posedge clk); #1;
    i_op_ready = 1'b0;
    check({tag, "_accepted"}, {31'd0, o_op_valid}, 32'd0);
    check({tag, "_busy_ready"}, {31'd0, o_ready}, 32'd0);
    i_res_valid = 1'b1;
    i_res_data  = res;
    i_res_error = err;
    @(posedge clk); #1;
    i_res_valid = 1'b0;
    i_res_error = 1'b0;
  endtask

  // Calculator model: x is the running value, y the second operand being typed.
  logic [15:0] m_x, m_y;
  logic [1:0]  m_op;
  int          m_nd;
  int          m_phase;  // 0 typing x, 1 operator chosen, 2 typing y, 3 showing result
  bit          m_err;

  task automatic model_key(input int k, output bit req, output bit chained, output logic [1:0] nop);
    req = 0; chained = 0; nop = 2'(k - K_ADD);
    if (k == K_AC) begin
      m_x = 0; m_y = 0; m_nd = 0; m_op = 0; m_phase = 0; m_err = 0;
    end else if (m_err) begin
    end else if (k <= 9) begin
      if (m_phase == 0) begin
        if (m_nd < 4) begin m_x = 16'(m_x * 10 + k); m_nd++; end
      end else if (m_phase == 1) begin
        m_y = 16'(k); m_nd = 1; m_phase = 2;
      end else if (m_phase == 2) begin
        if (m_nd < 4) begin m_y = 16'(m_y * 10 + k); m_nd++; end
      end else begin
        m_x = 16'(k); m_nd = 1; m_phase = 0;
      end
    end else if (k >= K_ADD && k <= K_DIV) begin
      if (m_phase == 2) begin req = 1; chained = 1; end
      else begin m_op = 2'(k - K_ADD); m_phase = 1; end
    end else if (k == K_EQ) begin
      if (m_phase == 2) req = 1;
    end
  endtask

  task automatic alu_model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                           output logic [15:0] res, output logic err);
    int sa = $signed(a);
    int sb = $signed(b);
    int r = 0;
    err = 0;
    case (op)
      2'd0: r = sa + sb;
      2'd1: r = sa - sb;
      2'd2: r = sa * sb;
      default: if (sb == 0) err = 1; else r = sa / sb;
    endcase
    if (r > 32767 || r < -32768) err = 1;
    res = 16'(r);
  endtask

  function automatic logic [15:0] model_disp();
    if (m_err) return 16'd0;
    return (m_phase == 2) ? m_y : m_x;
  endfunction

  logic [15:0] res;
  logic        err, req, chained;
  logic [1:0]  nop;
  int          k, r;

  initial begin
    // Reset state
    #2;
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_valid", {31'd0, o_op_valid}, 32'd0);
    check("rst_disp", {16'd0, o_disp_value}, 32'd0);
    check("rst_err", {31'd0, o_disp_error}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // 12 + 34 = 46
    send_key(1); send_key(2); send_key(K_ADD);
    check("t1_opwait_disp", {16'd0, o_disp_value}, 32'd12);
    send_key(3); send_key(4);
    check("t1_b_disp", {16'd0, o_disp_value}, 32'd34);
    send_key(K_EQ);
    alu_serve(16'd12, 16'd34, 2'd0, 16'd46, 1'b0, 0, "t1_req");
    check("t1_res_disp", {16'd0, o_disp_value}, 32'd46);
    check("t1_res_ready", {31'd0, o_ready}, 32'd1);

    // Chain: 9 * 8 - 2 =
    send_key(9); send_key(K_MUL); send_key(8); send_key(K_SUB);
    alu_serve(16'd9, 16'd8, 2'd2, 16'd72, 1'b0, 0, "t2_req1");
    check("t2_chain_disp", {16'd0, o_disp_value}, 32'd72);
    check("t2_chain_opc", {30'd0, o_opcode}, 32'd1);
    send_key(2); send_key(K_EQ);
    alu_serve(16'd72, 16'd2, 2'd1, 16'd70, 1'b0, 0, "t2_req2");
    check("t2_final_disp", {16'd0, o_disp_value}, 32'd70);

    // Digit limit and operator replacement
    send_key(K_AC);
    send_key(1); send_key(2); send_key(3); send_key(4); send_key(5);
    check("t3_limit_disp", {16'd0, o_disp_value}, 32'd1234);
    send_key(K_ADD); send_key(K_SUB); send_key(6); send_key(K_EQ);
    alu_serve(16'd1234, 16'd6, 2'd1, 16'd1228, 1'b0, 0, "t3_req");

    // Error path
    send_key(5); send_key(K_DIV); send_key(0); send_key(K_EQ);
    alu_serve(16'd5, 16'd0, 2'd3, 16'd0, 1'b1, 0, "t4_req");
    check("t4_err_flag", {31'd0, o_disp_error}, 32'd1);
    check("t4_err_disp", {16'd0, o_disp_value}, 32'd0);
    send_key(7);
    check("t4_drop_flag", {31'd0, o_disp_error}, 32'd1);
    check("t4_drop_disp", {16'd0, o_disp_value}, 32'd0);
    send_key(K_AC);
    check("t4_ac_flag", {31'd0, o_disp_error}, 32'd0);
    check("t4_ac_disp", {16'd0, o_disp_value}, 32'd0);
    send_key(3);
    check("t4_enter_a", {16'd0, o_disp_value}, 32'd3);
    send_key(K_AC);

    // Backpressure with key 4 held upstream
    send_key(1); send_key(K_ADD); send_key(2); send_key(K_EQ);
    i_valid = 1'b1; i_data = 5'd4;
    alu_serve(16'd1, 16'd2, 2'd0, 16'd3, 1'b0, 3, "t5_req");
    check("t5_res_disp", {16'd0, o_disp_value}, 32'd3);
    check("t5_res_ready", {31'd0, o_ready}, 32'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("t5_key_taken", {16'd0, o_disp_value}, 32'd4);

    // Reset while waiting for the result
    send_key(K_AC);
    send_key(7); send_key(K_ADD); send_key(1); send_key(K_EQ);
    i_op_ready = 1'b1;
    @(posedge clk); #1;
    i_op_ready = 1'b0;
    check("t6_waitres_ready", {31'd0, o_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_ready", {31'd0, o_ready}, 32'd1);
    check("t6_rst_valid", {31'd0, o_op_valid}, 32'd0);
    check("t6_rst_disp", {16'd0, o_disp_value}, 32'd0);
    check("t6_rst_a", {16'd0, o_op_a}, 32'd0);
    check("t6_rst_b", {16'd0, o_op_b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    i_res_valid = 1'b1; i_res_data = 16'd99;
    @(posedge clk); #1;
    i_res_valid = 1'b0;
    check("t6_late_a", {16'd0, o_op_a}, 32'd0);
    check("t6_late_disp", {16'd0, o_disp_value}, 32'd0);
    check("t6_late_err", {31'd0, o_disp_error}, 32'd0);
    send_key(5);
    check("t6_after_digit", {16'd0, o_disp_value}, 32'd5);

    // Randomized key stream against the model
    send_key(K_AC);
    m_x = 0; m_y = 0; m_nd = 0; m_op = 0; m_phase = 0; m_err = 0;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55) k = $urandom_range(0, 9);
      else if (r < 78) k = $urandom_range(K_ADD, K_DIV);
      else if (r < 88) k = K_EQ;
      else if (r < 93) k = K_AC;
      else if (r < 96) k = $urandom_range(10, 15);
      else k = $urandom_range(22, 31);
      send_key(k);
      model_key(k, req, chained, nop);
      if (req) begin
        alu_model(m_x, m_y, m_op, res, err);
        alu_serve(m_x, m_y, m_op, res, err, $urandom_range(0, 2), "rnd_req");
        if (err) m_err = 1;
        else begin
          m_x = res;
          if (chained) begin m_op = nop; m_phase = 1; end
          else m_phase = 3;
        end
      end
      check("rnd_disp", {16'd0, o_disp_value}, {16'd0, model_disp()});
      check("rnd_err", {31'd0, o_disp_error}, {31'd0, m_err});
      check("rnd_ready", {31'd0, o_ready}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_input_parser.md
# calc_input_parser

Consumes debounced key codes from the keypad/button reader over a valid/ready handshake. Assembles decimal operands and tracks the pending operator. Issues two-operand requests to the downstream ALU and folds ALU results back in as the running value, which supports chained expressions (`12+3*4=` evaluates left to right). Also drives the value and error flag shown on the display.

## Interface
- `WIDTH`, 16: operand/result width, two's complement.
- `MAX_DIGITS`, 4: maximum decimal digits per entered operand. Constraint: 10^MAX_DIGITS−1 ≤ 2^(WIDTH−1)−1.
- `clk` in 1: clock. One clock domain; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `i_data` in 5: key code. 0–9 digit; 16 AC; 17 ADD; 18 SUB; 19 MUL; 20 DIV; 21 EQ; 10–15 and 22–31 ignored.
- `i_valid` in 1: key code valid.
- `o_ready` out 1: parser accepts a key. A key is consumed when `i_valid & o_ready` at an edge.
- `o_op_a`, `o_op_b` out WIDTH: ALU operands.
- `o_opcode` out 2: 00 add, 01 sub, 10 mul, 11 div.
- `o_op_valid` out 1: ALU request valid.
- `i_op_ready` in 1: ALU accepts the request.
- `i_res_data` in WIDTH: ALU result.
- `i_res_error` in 1: ALU error (divide by zero, overflow); qualified by `i_res_valid`.
- `i_res_valid` in 1: one-cycle result strobe.
- `o_disp_value` out WIDTH: value to display.
- `o_disp_error` out 1: error indicator.

## Operation
- Registers:
  - A, B: WIDTH bits each.
  - `digits`: counts 0..MAX_DIGITS.
  - `op`: current opcode, 2 bits.
  - `next_op`: opcode, 2 bits.
  - `chain`: 1 bit.
- Digit entry: `X ← X*10 + d` and `digits++`, only while `digits < MAX_DIGITS`. Further digits are consumed and dropped.
- States:
  - ENTER_A:
    - digit → accumulate A.
    - operator → `op` = operator, go to OP_WAIT.
    - EQ or ignored code → no change.
  - OP_WAIT:
    - digit → B = d, `digits` = 1, go to ENTER_B.
    - operator → replace `op`.
    - EQ → ignored.
  - ENTER_B:
    - digit → accumulate B.
    - operator → `next_op` = operator, `chain` = 1, go to ISSUE.
    - EQ → `chain` = 0, go to ISSUE.
  - ISSUE: `o_op_valid` = 1; move to WAIT_RES at the edge where `i_op_ready` = 1.
  - WAIT_RES: on `i_res_valid`:
    - if `i_res_error` → ERROR.
    - else A = `i_res_data`; if `chain` = 1, `op` = `next_op` and go to OP_WAIT; otherwise go to SHOW_RES.
  - SHOW_RES:
    - digit → A = d, `digits` = 1, go to ENTER_A (starts a new calculation).
    - operator → `op` = operator, go to OP_WAIT (continues from the result).
    - EQ → ignored.
  - ERROR: every key except AC is consumed and dropped.
- AC, in any state where it is accepted: A = B = 0, `digits` = 0, `op` = 00, `chain` = 0, go to ENTER_A.
- `o_ready` = 1 in ENTER_A, OP_WAIT, ENTER_B, SHOW_RES and ERROR; 0 in ISSUE and WAIT_RES. AC therefore cannot abort an in-flight ALU operation.
- `o_op_a` = A, `o_op_b` = B, `o_opcode` = `op`. These hold stable throughout ISSUE.
- Display:
  - ENTER_A, OP_WAIT, SHOW_RES → A.
  - ENTER_B, ISSUE, WAIT_RES → B.
  - ERROR → value 0, `o_disp_error` = 1. `o_disp_error` = 0 in every other state.
- Ignored codes (10–15, 22–31) are consumed in all accepting states with no effect.
- `i_res_valid` outside WAIT_RES is ignored.

## Timing
- Reset values, applied immediately and asynchronously:
  - state ENTER_A.
  - A, B, `digits`, `op`, `next_op`, `chain` all 0.
  - `o_op_valid` = 0, `o_disp_value` = 0, `o_disp_error` = 0.
  - `o_ready` = 1.
- A key consumed at edge N is reflected in state and outputs after edge N (registered, one-cycle latency).
- ENTER_B + operator/EQ consumed at edge N → `o_op_valid` = 1 from edge N until the edge where `i_op_ready` = 1 (inclusive), then 0.
- Operands and opcode do not change while `o_op_valid` = 1.
- `i_res_valid` at edge M → A, state and display updated after edge M. `o_ready` returns to 1 at the same time.
- Keys arriving while `o_ready` = 0 are not consumed. The upstream block holds them.
- `rst` asserted in any state, including ISSUE or WAIT_RES, forces the reset values immediately. A late `i_res_valid` after reset release is ignored.

## Test plan
- Operands and result: keys 1,2,ADD,3,4,EQ with an ALU model returning 46. Required:
  - `o_op_a` = 12, `o_op_b` = 34, `o_opcode` = 00.
  - Display then 46, state SHOW_RES.
- Chaining: keys 9,MUL,8,SUB; ALU returns 72. Required:
  - state OP_WAIT, display 72, `o_opcode` = 01.
  - Then keys 2,EQ → request with `o_op_a` = 72, `o_op_b` = 2.
- Digit limit and operator replacement: keys 1,2,3,4,5 → A = 1234. Then ADD,SUB,6,EQ → request with `o_opcode` = 01, `o_op_b` = 6.
- Error: keys 5,DIV,0,EQ; ALU returns `i_res_error` = 1. Required:
  - `o_disp_error` = 1, display 0.
  - Key 7 is consumed with no effect.
  - AC → `o_disp_error` = 0, display 0, state ENTER_A.
- Backpressure: hold `i_op_ready` = 0 for 3 cycles with `i_valid` = 1 and key 4 presented. Required:
  - `o_op_valid` stays 1 with operands and opcode stable.
  - `o_ready` = 0; the key is consumed only after the result returns.
- Reset mid-operation: assert `rst` in WAIT_RES, then pulse `i_res_valid` after release. Required: all outputs at reset values, A stays 0.
